// File: rtl/multi_channel_pulse_timestamper.sv
// ---------------------------------------------------------------------------
// multi_channel_pulse_timestamper
//
// Timestamps and width-measures envelope pulses from CHANNELS TS4231 E outputs
// against one shared free-running counter. Each channel produces records of
// {channel, timestamp, width}. A round-robin arbiter moves them into a
// first-word-fall-through FIFO, which drains through a valid/ready stream.
//
// Build option:
//   PULSE_MIN_WIDTH_FILTER_EN  When defined, a pulse shorter than MIN_WIDTH
//                              clk cycles is discarded at its falling edge.
//                              It is not counted as dropped. When undefined,
//                              every pulse is recorded.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high
//   e                asynchronous envelope inputs, high = light present
//   enable           0 stops new pulses from being armed; the FIFO still drains
//   pulse_valid      FIFO head valid
//   pulse_ready      consumer accepts the head record
//   pulse_channel    channel index of the head record
//   pulse_timestamp  counter value at the synchronised rising edge
//   pulse_width      synchronised high time in clk cycles (saturating)
//   dropped_count    records lost to channel overrun (saturating)
//   fifo_level       current FIFO occupancy
// ---------------------------------------------------------------------------
module multi_channel_pulse_timestamper #(
  parameter int CHANNELS   = 4,
  parameter int TS_WIDTH   = 24,
  parameter int PW_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_WIDTH  = 4,
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] e,
  input  logic                enable,
  output logic                pulse_valid,
  input  logic                pulse_ready,
  output logic [CH_W-1:0]     pulse_channel,
  output logic [TS_WIDTH-1:0] pulse_timestamp,
  output logic [PW_WIDTH-1:0] pulse_width,
  output logic [15:0]         dropped_count,
  output logic [LVL_W-1:0]    fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = CH_W + TS_WIDTH + PW_WIDTH;

`ifdef PULSE_MIN_WIDTH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_PENDING,
    ST_MEASURE_HELD
  } ch_state_t;

  // -------------------------------------------------------------------------
  // Shared timestamp counter and synchroniser fill tracker
  // -------------------------------------------------------------------------
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  // fill_q[1] goes high once both synchroniser stages hold real pin samples
  // instead of reset zeros. Arming must wait for this. Otherwise a pin that is
  // high at reset release would look like a low-to-high edge.
  logic [1:0]          fill_q, fill_d;

  always_comb begin
    ts_d   = ts_q + TS_WIDTH'(1);
    fill_d = {fill_q[0], 1'b1};
  end

  // Per-channel signals used by the arbiter and the FIFO
  logic [CHANNELS-1:0]               req;
  logic [CHANNELS-1:0]               grant_vec;
  logic [CHANNELS-1:0]               drop_vec;
  logic [CHANNELS-1:0][TS_WIDTH-1:0] rec_ts_all;
  logic [CHANNELS-1:0][PW_WIDTH-1:0] rec_w_all;

  // -------------------------------------------------------------------------
  // Channel front ends: synchroniser, edge detect, measurement FSM
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    ch_state_t           state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                prev_q, prev_d;
    logic                armed_q, armed_d;
    logic [TS_WIDTH-1:0] cur_ts_q, cur_ts_d;
    logic [TS_WIDTH-1:0] rec_ts_q, rec_ts_d;
    logic [PW_WIDTH-1:0] cur_w_q, cur_w_d;
    logic [PW_WIDTH-1:0] rec_w_q, rec_w_d;
    logic [PW_WIDTH-1:0] cur_w_inc;
    logic                rise, fall, start, keep, drop, grant;

    assign rise      = sync2_q & ~prev_q;
    assign fall      = ~sync2_q & prev_q;
    assign start     = rise & armed_q & enable;
    assign grant     = grant_vec[gi];
    assign cur_w_inc = (&cur_w_q) ? cur_w_q : cur_w_q + PW_WIDTH'(1);
    // Evaluated at the falling edge, when cur_w_q holds the full high time.
    assign keep      = !FILTER_EN || (cur_w_q >= PW_WIDTH'(MIN_WIDTH));

    always_comb begin
      sync1_d  = e[gi];
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      armed_d  = armed_q | (fill_q[1] & ~sync2_q);
      state_d  = state_q;
      cur_ts_d = cur_ts_q;
      cur_w_d  = cur_w_q;
      rec_ts_d = rec_ts_q;
      rec_w_d  = rec_w_q;
      drop     = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_MEASURE;
            cur_ts_d = ts_q;
            cur_w_d  = PW_WIDTH'(1);
          end
        end

        ST_MEASURE: begin
          if (fall) begin
            if (keep) begin
              rec_ts_d = cur_ts_q;
              rec_w_d  = cur_w_q;
              state_d  = ST_PENDING;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (sync2_q) begin
            cur_w_d = cur_w_inc;
          end
        end

        ST_PENDING: begin
          // A new pulse may begin while the previous record waits. If the old
          // record is granted in the same cycle, this is an ordinary measurement.
          if (start) begin
            cur_ts_d = ts_q;
            cur_w_d  = PW_WIDTH'(1);
            state_d  = grant ? ST_MEASURE : ST_MEASURE_HELD;
          end else if (grant) begin
            state_d = ST_IDLE;
          end
        end

        ST_MEASURE_HELD: begin
          if (fall) begin
            if (grant) begin
              // The old record leaves this cycle, so the new one can take its place.
              if (keep) begin
                rec_ts_d = cur_ts_q;
                rec_w_d  = cur_w_q;
                state_d  = ST_PENDING;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              // The old record is still held, so the new one is lost.
              state_d = ST_PENDING;
              drop    = keep;
            end
          end else begin
            if (sync2_q) begin
              cur_w_d = cur_w_inc;
            end
            if (grant) begin
              state_d = ST_MEASURE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        prev_q   <= 1'b0;
        armed_q  <= 1'b0;
        cur_ts_q <= '0;
        rec_ts_q <= '0;
        cur_w_q  <= '0;
        rec_w_q  <= '0;
      end else begin
        state_q  <= state_d;
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        prev_q   <= prev_d;
        armed_q  <= armed_d;
        cur_ts_q <= cur_ts_d;
        rec_ts_q <= rec_ts_d;
        cur_w_q  <= cur_w_d;
        rec_w_q  <= rec_w_d;
      end
    end

    assign req[gi]        = (state_q == ST_PENDING) || (state_q == ST_MEASURE_HELD);
    assign drop_vec[gi]   = drop;
    assign rec_ts_all[gi] = rec_ts_q;
    assign rec_w_all[gi]  = rec_w_q;
  end

  // -------------------------------------------------------------------------
  // Round-robin arbiter: at most one grant per cycle, none while FIFO full
  // -------------------------------------------------------------------------
  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] grant_idx;
  logic            grant_any;
  logic            fifo_full;
  int              idx;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    rr_d      = rr_q;
    idx       = 0;
    if (!fifo_full) begin
      for (int i = 0; i < CHANNELS; i++) begin
        idx = int'(rr_q) + i;
        if (idx >= CHANNELS) begin
          idx = idx - CHANNELS;
        end
        if (!grant_any && req[idx[CH_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = idx[CH_W-1:0];
        end
      end
    end
    if (grant_any) begin
      grant_vec[grant_idx] = 1'b1;
      rr_d = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Dropped-record counter: several channels may overrun in the same cycle
  // -------------------------------------------------------------------------
  logic [15:0] dropped_q, dropped_d;
  logic [4:0]  drop_n;
  logic [16:0] drop_sum;

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      drop_n = drop_n + 5'(drop_vec[i]);
    end
    drop_sum  = {1'b0, dropped_q} + 17'(drop_n);
    dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // -------------------------------------------------------------------------
  // Output FIFO. The head is read combinationally, so a record granted in
  // cycle t is visible at the outputs in cycle t+1.
  // -------------------------------------------------------------------------
  logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [REC_W-1:0] push_data, head;

  assign fifo_full   = (count_q == LVL_W'(FIFO_DEPTH));
  assign pulse_valid = (count_q != '0);
  assign pop         = pulse_valid & pulse_ready;
  assign push        = grant_any;
  assign push_data   = {grant_idx, rec_ts_all[grant_idx], rec_w_all[grant_idx]};
  assign head        = fifo_mem[rd_ptr_q];

  // Zero the head fields while empty, so the outputs never show a stale entry.
  assign {pulse_channel, pulse_timestamp, pulse_width} = pulse_valid ? head : '0;
  assign fifo_level    = count_q;
  assign dropped_count = dropped_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q      <= '0;
      fill_q    <= '0;
      rr_q      <= '0;
      dropped_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      ts_q      <= ts_d;
      fill_q    <= fill_d;
      rr_q      <= rr_d;
      dropped_q <= dropped_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule
